// File: rtl/argmax_classifier_if.sv
// Score-vector handshake and classification result bundle for argmax_classifier.
// margin/low_conf exist only when CONFIDENCE_MARGIN_EN is defined.
interface argmax_classifier_if #(
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_W     = 26,
    parameter int IDX_W       = 4
);
    logic [NUM_CLASSES*SCORE_W-1:0] value;
    logic                           in_valid;
    logic                           in_ready;
    logic [IDX_W-1:0]               digit;
    logic [SCORE_W-1:0]             max_value;
    logic                           done;
    logic                           busy;
`ifdef CONFIDENCE_MARGIN_EN
    logic [SCORE_W:0]               margin;
    logic                           low_conf;

    modport master (output value, in_valid,
                    input  in_ready, digit, max_value, done, busy, margin, low_conf);
    modport slave  (input  value, in_valid,
                    output in_ready, digit, max_value, done, busy, margin, low_conf);
`else
    modport master (output value, in_valid,
                    input  in_ready, digit, max_value, done, busy);
    modport slave  (input  value, in_valid,
                    output in_ready, digit, max_value, done, busy);
`endif
endinterface

// File: rtl/argmax_classifier.sv
// Final classifier: captures NUM_CLASSES signed 8.18 scores, scans one compare per cycle,
// reports winning index/score with a done pulse. Optional macro CONFIDENCE_MARGIN_EN adds margin/low_conf.
module argmax_classifier #(
    parameter int               NUM_CLASSES   = 10,
    parameter int               SCORE_W       = 26,
    parameter int               IDX_W         = 4,
    parameter logic [SCORE_W:0] MARGIN_THRESH = 27'd262144
) (
    input  logic               clk,
    input  logic               GlobalReset,
    argmax_classifier_if.slave bus
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                    state;
    logic signed [SCORE_W-1:0] score_buf [NUM_CLASSES];
    logic signed [SCORE_W-1:0] best_val;
    logic [IDX_W-1:0]          best_idx;
    logic [IDX_W-1:0]          idx;

    logic signed [SCORE_W-1:0] cand;
    logic signed [SCORE_W-1:0] nxt_best_val;
    logic [IDX_W-1:0]          nxt_best_idx;
    logic                      new_best;

    // Strictly-greater replacement keeps the lowest index on ties.
    always_comb begin
        cand         = score_buf[idx];
        new_best     = (cand > best_val);
        nxt_best_val = best_val;
        nxt_best_idx = best_idx;
        if (new_best) begin
            nxt_best_val = cand;
            nxt_best_idx = idx;
        end
    end

    assign bus.in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            state         <= IDLE;
            idx           <= '0;
            best_val      <= '0;
            best_idx      <= '0;
            bus.digit     <= '0;
            bus.max_value <= '0;
            bus.done      <= 1'b0;
            bus.busy      <= 1'b0;
            for (int k = 0; k < NUM_CLASSES; k++) score_buf[k] <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        for (int k = 0; k < NUM_CLASSES; k++)
                            score_buf[k] <= bus.value[k*SCORE_W +: SCORE_W];
                        best_val <= bus.value[SCORE_W-1:0];
                        best_idx <= '0;
                        idx      <= IDX_W'(1);
                        state    <= SCAN;
                        bus.busy <= 1'b1;
                    end
                end
                SCAN: begin
                    best_val <= nxt_best_val;
                    best_idx <= nxt_best_idx;
                    if (idx == LAST_IDX) begin
                        bus.digit     <= nxt_best_idx;
                        bus.max_value <= nxt_best_val;
                        bus.done      <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CONFIDENCE_MARGIN_EN
    logic signed [SCORE_W-1:0] second_val;
    logic signed [SCORE_W-1:0] nxt_second_val;
    logic                      second_vld;

    // Difference at one extra bit so the extreme score pair cannot overflow.
    function automatic logic [SCORE_W:0] calc_margin(input logic signed [SCORE_W-1:0] hi,
                                                     input logic signed [SCORE_W-1:0] lo);
        calc_margin = {hi[SCORE_W-1], hi} - {lo[SCORE_W-1], lo};
    endfunction

    always_comb begin
        nxt_second_val = second_val;
        if (new_best)
            nxt_second_val = best_val;
        else if (!second_vld || cand > second_val)
            nxt_second_val = cand;
    end

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            second_val   <= '0;
            second_vld   <= 1'b0;
            bus.margin   <= '0;
            bus.low_conf <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.in_valid) begin
                second_val <= bus.value[SCORE_W-1:0];
                second_vld <= 1'b0;
            end
        end else begin
            second_val <= nxt_second_val;
            second_vld <= 1'b1;
            if (idx == LAST_IDX) begin
                bus.margin   <= calc_margin(nxt_best_val, nxt_second_val);
                bus.low_conf <= (calc_margin(nxt_best_val, nxt_second_val) < MARGIN_THRESH);
            end
        end
    end
`endif

endmodule

// File: tb/tb_argmax_classifier.sv
// Randomized + directed bench for argmax_classifier against a behavioural argmax model.
module tb_argmax_classifier;
    localparam int NC = 10;
    localparam int SW = 26;
    localparam int IW = 4;
    localparam int VW = NC * SW;

    logic clk = 1'b0;
    logic GlobalReset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    argmax_classifier_if #(.NUM_CLASSES(NC), .SCORE_W(SW), .IDX_W(IW)) bus ();

    argmax_classifier #(.NUM_CLASSES(NC), .SCORE_W(SW), .IDX_W(IW)) dut (
        .clk        (clk),
        .GlobalReset(GlobalReset),
        .bus        (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model: argmax over the whole vector ----------------
    function automatic int f_digit(input logic [VW-1:0] v);
        int d = 0;
        for (int k = 1; k < NC; k++)
            if ($signed(v[k*SW +: SW]) > $signed(v[d*SW +: SW])) d = k;
        return d;
    endfunction

    function automatic logic [SW-1:0] f_max(input logic [VW-1:0] v);
        return v[f_digit(v)*SW +: SW];
    endfunction

    function automatic logic [SW:0] f_margin(input logic [VW-1:0] v);
        int d = f_digit(v);
        logic signed [SW:0] b, s, t;
        logic first = 1'b1;
        b = $signed(v[d*SW +: SW]);
        s = '0;
        for (int k = 0; k < NC; k++) begin
            if (k != d) begin
                t = $signed(v[k*SW +: SW]);
                if (first || t > s) s = t;
                first = 1'b0;
            end
        end
        return b - s;
    endfunction

    int             m_cnt = 0;
    logic           m_done = 1'b0;
    logic [IW-1:0]  m_digit = '0;
    logic [SW-1:0]  m_max = '0;
    logic [SW:0]    m_margin = '0;
    logic [IW-1:0]  p_digit = '0;
    logic [SW-1:0]  p_max = '0;
    logic [SW:0]    p_margin = '0;

    always @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            m_cnt    <= 0;
            m_done   <= 1'b0;
            m_digit  <= '0;
            m_max    <= '0;
            m_margin <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt == 0) begin
                if (bus.in_valid === 1'b1) begin
                    p_digit  <= IW'(f_digit(bus.value));
                    p_max    <= f_max(bus.value);
                    p_margin <= f_margin(bus.value);
                    m_cnt    <= NC - 1;
                end
            end else begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_done   <= 1'b1;
                    m_digit  <= p_digit;
                    m_max    <= p_max;
                    m_margin <= p_margin;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        chk("cyc_in_ready", bus.in_ready, m_cnt == 0);
        chk("cyc_busy", bus.busy, m_cnt != 0);
        chk("cyc_done", bus.done, m_done);
        chk("cyc_digit", bus.digit, m_digit);
        chk("cyc_max_value", bus.max_value, m_max);
`ifdef CONFIDENCE_MARGIN_EN
        chk("cyc_margin", bus.margin, m_margin);
        chk("cyc_low_conf", bus.low_conf, m_margin < 27'd262144);
`endif
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [VW-1:0] pack_all(input logic [SW-1:0] s);
        logic [VW-1:0] v;
        for (int k = 0; k < NC; k++) v[k*SW +: SW] = s;
        return v;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int k = 0; k < NC; k++) begin
            case ($urandom_range(0, 5))
                0:       v[k*SW +: SW] = 26'h2000000;
                1:       v[k*SW +: SW] = 26'h1FFFFFF;
                2:       v[k*SW +: SW] = SW'($urandom_range(0, 3));
                default: v[k*SW +: SW] = SW'($urandom);
            endcase
        end
        return v;
    endfunction

    task automatic start(input logic [VW-1:0] v);
        bus.value    = v;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (1) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus.done === 1'b1) break;
            if (n >= limit) begin
                checks++;
                failures++;
                $display("FAIL done_timeout actual=no_done_after_%0d required=done", n);
                break;
            end
        end
    endtask

    logic [VW-1:0] v, v2;
    int            n, c1, c2;

    initial begin
        bus.in_valid = 1'b0;
        bus.value    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_digit", bus.digit, 0);
        chk("rst_max_value", bus.max_value, 0);
        @(negedge clk);
        GlobalReset = 1'b1;

        // all ties at 1.0
        v = pack_all(26'h0040000);
        chk("pin_tie_digit", f_digit(v), 0);
        chk("pin_tie_margin", f_margin(v), 0);
        start(v);
        wait_done(20, n);
        chk("tie_latency", n, 9);
        chk("tie_digit", bus.digit, 0);
        chk("tie_max", bus.max_value, 26'h0040000);

        // class 7 = 5.0
        v = pack_all(26'h0040000);
        v[7*SW +: SW] = 26'h0140000;
        chk("pin_c7_digit", f_digit(v), 7);
        chk("pin_c7_margin", f_margin(v), 27'h100000);
        start(v);
        wait_done(20, n);
        chk("c7_digit", bus.digit, 7);
        chk("c7_max", bus.max_value, 26'h0140000);

        // all negative, class 3 = -0.5
        for (int k = 0; k < NC; k++) v[k*SW +: SW] = SW'(-(k + 1) * 262144);
        v[3*SW +: SW] = 26'h3FE0000;
        chk("pin_neg_max", f_max(v), 26'h3FE0000);
        start(v);
        wait_done(20, n);
        chk("neg_digit", bus.digit, 3);
        chk("neg_max", bus.max_value, 26'h3FE0000);

        // extremes, with an ignored in_valid pulse mid-scan
        v = '0;
        v[9*SW +: SW] = 26'h1FFFFFF;
        v[0*SW +: SW] = 26'h2000000;
        start(v);
        repeat (3) @(posedge clk);
        #1;
        bus.value    = pack_all(26'h1000000);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_done(20, n);
        chk("ext_digit", bus.digit, 9);
        chk("ext_max", bus.max_value, 26'h1FFFFFF);

        // back-to-back: second vector offered in the done cycle
        v = '0;
        v[2*SW +: SW] = 26'h00C0000;
        v2 = '0;
        v2[5*SW +: SW] = 26'h0080000;
        start(v);
        wait_done(20, n);
        c1 = cyc;
        chk("b2b_first_digit", bus.digit, 2);
        start(v2);
        wait_done(20, n);
        c2 = cyc;
        chk("b2b_gap", c2 - c1, 10);
        chk("b2b_second_digit", bus.digit, 5);
        chk("b2b_second_max", bus.max_value, 26'h0080000);

        // asynchronous reset mid-scan
        v = pack_all(26'h0040000);
        v[8*SW +: SW] = 26'h0100000;
        start(v);
        repeat (4) @(posedge clk);
        #2;
        GlobalReset = 1'b0;
        #1;
        chk("arst_digit", bus.digit, 0);
        chk("arst_max", bus.max_value, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_in_ready", bus.in_ready, 1);
        chk("arst_done", bus.done, 0);
        @(negedge clk);
        @(negedge clk);
        GlobalReset = 1'b1;
        repeat (12) begin
            @(negedge clk);
            chk("arst_no_done", bus.done, 0);
        end
        start(v);
        wait_done(20, n);
        chk("post_rst_latency", n, 9);
        chk("post_rst_digit", bus.digit, 8);
        chk("post_rst_max", bus.max_value, 26'h0100000);

        // randomized traffic, model-checked every cycle
        repeat (400) begin
            @(posedge clk);
            #1;
            bus.in_valid = ($urandom_range(0, 2) == 0);
            bus.value    = rand_vec();
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
